goodcrc_tx: RTL

GOODCRC_TX -- requirements
Module: goodcrc_tx

---
 rtl/tcpc_pkg.sv | 26 ++
 rtl/goodcrc_tx_if.sv | 30 +++
 rtl/goodcrc_hdr_build.sv | 27 ++
 rtl/goodcrc_tx.sv | 132 +++++++++++++
 4 files changed

// File: rtl/tcpc_pkg.sv
// tcpc_pkg: shared types and constants for the TCPC protocol-layer blocks.
// Holds the GoodCRC FSM encoding, SOP type codes and watchdog length.
package tcpc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND_B0,
        ST_SEND_B1,
        ST_WAIT_DONE
    } gc_state_e;

    localparam logic [4:0] GOODCRC_MSG_TYPE = 5'b00001;

    localparam logic [2:0] SOP_TYPE_SOP   = 3'd0;
    localparam logic [2:0] SOP_TYPE_SOPP  = 3'd1;
    localparam logic [2:0] SOP_TYPE_SOPPP = 3'd2;

    localparam int unsigned GOODCRC_TIMEOUT_CYCLES = 255;
    localparam logic [7:0] GOODCRC_TMO_LAST = 8'(GOODCRC_TIMEOUT_CYCLES - 1);

    function automatic logic sop_known(input logic [2:0] t);
        return (t == SOP_TYPE_SOP) || (t == SOP_TYPE_SOPP) ||
               (t == SOP_TYPE_SOPPP);
    endfunction

endpackage

// File: rtl/goodcrc_tx_if.sv
// goodcrc_tx_if: byte-stream handshake between the GoodCRC sender and PHY.
// master = GoodCRC sender, slave = PHY transmit path.
interface goodcrc_tx_if;

    logic [7:0] phy_tx_data;
    logic       phy_tx_valid;
    logic       phy_tx_ready;
    logic [2:0] phy_tx_sop_type;
    logic       phy_tx_done;
    logic       phy_tx_fail;

    modport master (
        output phy_tx_data,
        output phy_tx_valid,
        output phy_tx_sop_type,
        input  phy_tx_ready,
        input  phy_tx_done,
        input  phy_tx_fail
    );

    modport slave (
        input  phy_tx_data,
        input  phy_tx_valid,
        input  phy_tx_sop_type,
        output phy_tx_ready,
        output phy_tx_done,
        output phy_tx_fail
    );

endinterface

// File: rtl/goodcrc_hdr_build.sv
// goodcrc_hdr_build: combinational GoodCRC message header former.
// Role bits depend on whether the reply goes to SOP or a cable plug.
module goodcrc_hdr_build
    import tcpc_pkg::*;
(
    input  logic [7:0]  info,
    input  logic [7:0]  rx_byte1,
    input  logic [2:0]  sop_type,
    output logic [15:0] header
);

    logic is_sop;
    logic unused_bits;

    assign is_sop = (sop_type == SOP_TYPE_SOP);
    assign unused_bits = ^{info[7:5], rx_byte1[7:4], rx_byte1[0]};

    always_comb begin
        header        = 16'h0000;
        header[4:0]   = GOODCRC_MSG_TYPE;
        header[5]     = is_sop ? info[3] : 1'b0;
        header[7:6]   = info[2:1];
        header[8]     = is_sop ? info[0] : info[4];
        header[11:9]  = rx_byte1[3:1];
    end

endmodule

// File: rtl/goodcrc_tx.sv
// goodcrc_tx: sends the two-byte GoodCRC reply to the PHY and reports outcome.
// Define GOODCRC_TIMEOUT_EN to add a watchdog on the PHY end-of-frame.
module goodcrc_tx
    import tcpc_pkg::*;
(
    input  logic         clk,
    input  logic         hard_reset,
    input  logic [7:0]   MESSAGE_HEADER_INFO,
    input  logic [7:0]   RX_BUF_HEADER_BYTE_1,
    input  logic [2:0]   rx_sop_type,
    input  logic         goodcrc_req,
    goodcrc_tx_if.master phy,
    output logic         GoodCRC_Transmission_Complete,
    output logic         goodcrc_fail,
    output logic         goodcrc_busy
);

    gc_state_e   state_q, state_d;
    logic [15:0] hdr_q, hdr_d, hdr_w;
    logic [2:0]  sop_q, sop_d;
    logic        cmpl_q, cmpl_d;
    logic        fail_q, fail_d;
    logic        req_ok;

`ifdef GOODCRC_TIMEOUT_EN
    logic [7:0]  cnt_q, cnt_d;
    logic        tmo;

    assign tmo = (cnt_q == GOODCRC_TMO_LAST);
`endif

    goodcrc_hdr_build u_hdr (
        .info     (MESSAGE_HEADER_INFO),
        .rx_byte1 (RX_BUF_HEADER_BYTE_1),
        .sop_type (rx_sop_type),
        .header   (hdr_w)
    );

    assign req_ok = goodcrc_req && sop_known(rx_sop_type);

    always_comb begin
        state_d = state_q;
        hdr_d   = hdr_q;
        sop_d   = sop_q;
        cmpl_d  = 1'b0;
        fail_d  = 1'b0;
`ifdef GOODCRC_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (req_ok) begin
                    state_d = ST_SEND_B0;
                    hdr_d   = hdr_w;
                    sop_d   = rx_sop_type;
                end
            end
            ST_SEND_B0: begin
                if (phy.phy_tx_fail) begin
                    state_d = ST_IDLE;
                    fail_d  = 1'b1;
                end else if (phy.phy_tx_ready) begin
                    state_d = ST_SEND_B1;
                end
            end
            ST_SEND_B1: begin
                if (phy.phy_tx_fail) begin
                    state_d = ST_IDLE;
                    fail_d  = 1'b1;
                end else if (phy.phy_tx_ready) begin
                    state_d = ST_WAIT_DONE;
`ifdef GOODCRC_TIMEOUT_EN
                    cnt_d   = 8'd0;
`endif
                end
            end
            ST_WAIT_DONE: begin
                // a simultaneous discard outranks end-of-frame
                if (phy.phy_tx_fail) begin
                    state_d = ST_IDLE;
                    fail_d  = 1'b1;
                end else if (phy.phy_tx_done) begin
                    state_d = ST_IDLE;
                    cmpl_d  = 1'b1;
                end
`ifdef GOODCRC_TIMEOUT_EN
                else if (tmo) begin
                    state_d = ST_IDLE;
                    fail_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_q + 8'd1;
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (hard_reset) begin
            state_q <= ST_IDLE;
            hdr_q   <= 16'h0000;
            sop_q   <= 3'd0;
            cmpl_q  <= 1'b0;
            fail_q  <= 1'b0;
`ifdef GOODCRC_TIMEOUT_EN
            cnt_q   <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            hdr_q   <= hdr_d;
            sop_q   <= sop_d;
            cmpl_q  <= cmpl_d;
            fail_q  <= fail_d;
`ifdef GOODCRC_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign phy.phy_tx_valid = (state_q == ST_SEND_B0) ||
                              (state_q == ST_SEND_B1);
    assign phy.phy_tx_data  = (state_q == ST_SEND_B0) ? hdr_q[7:0]  :
                              (state_q == ST_SEND_B1) ? hdr_q[15:8] :
                                                        8'h00;
    assign phy.phy_tx_sop_type = sop_q;

    assign GoodCRC_Transmission_Complete = cmpl_q;
    assign goodcrc_fail = fail_q;
    assign goodcrc_busy = (state_q != ST_IDLE);

endmodule
